// File: rtl/pipelined_dot_product.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pipelined_dot_product                                 |
// | Streaming N-lane dot product: registered multiply stage, binary  |
// | adder tree and result register with optional accumulate.         |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module pipelined_dot_product #(
   parameter int N = 2,
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           in_acc,
   input  logic [N*W-1:0] a,
   input  logic [N*W-1:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   c
);

   localparam int c_DEPTH = $clog2(N);

   logic [W-1:0]       w_a [N];
   logic [W-1:0]       w_b [N];
   // Heap-ordered tree: node i sums nodes 2i and 2i+1; leaves N..2N-1 hold products.
   logic [W-1:0]       r_node [2:2*N-1];
   logic [c_DEPTH-1:0] r_vld;
   logic [c_DEPTH-1:0] r_tag;
   logic [W-1:0]       w_sum;
   logic [W-1:0]       r_c;
   logic               r_out_valid;
   logic               w_adv;

   assign w_adv     = !r_out_valid || out_ready;
   assign in_ready  = w_adv;
   assign w_sum     = r_node[2] + r_node[3];
   assign out_valid = r_out_valid;
   assign c         = r_c;

   generate
      for (genvar i = 0; i < N; i++) begin : g_lane
         assign w_a[i] = a[i*W +: W];
         assign w_b[i] = b[i*W +: W];
      end

      for (genvar i = 2; i < 2*N; i++) begin : g_node
         if (i >= N) begin : g_leaf
            always_ff @(posedge clk) begin
               if (reset) begin
                  r_node[i] <= '0;
               end else if (w_adv) begin
                  r_node[i] <= w_a[i-N] * w_b[i-N];
               end
            end
         end else begin : g_inner
            always_ff @(posedge clk) begin
               if (reset) begin
                  r_node[i] <= '0;
               end else if (w_adv) begin
                  r_node[i] <= r_node[2*i] + r_node[2*i+1];
               end
            end
         end
      end

      // Bit 0 tracks the multiply stage; the top bit tracks the level feeding c.
      for (genvar s = 0; s < c_DEPTH; s++) begin : g_stage
         if (s == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (reset) begin
                  r_vld[s] <= 1'b0;
                  r_tag[s] <= 1'b0;
               end else if (w_adv) begin
                  r_vld[s] <= in_valid;
                  r_tag[s] <= in_acc;
               end
            end
         end else begin : g_next
            always_ff @(posedge clk) begin
               if (reset) begin
                  r_vld[s] <= 1'b0;
                  r_tag[s] <= 1'b0;
               end else if (w_adv) begin
                  r_vld[s] <= r_vld[s-1];
                  r_tag[s] <= r_tag[s-1];
               end
            end
         end
      end
   endgenerate

   // A bubble clears out_valid but leaves c intact so later accumulates still build on it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_c         <= '0;
         r_out_valid <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= r_vld[c_DEPTH-1];
         if (r_vld[c_DEPTH-1]) begin
            r_c <= r_tag[c_DEPTH-1] ? (r_c + w_sum) : w_sum;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_dot_product.sv
`default_nettype none
// Bench for pipelined_dot_product: an N=2 instance checked every cycle
// against an operation-level model, plus an N=4 instance for latency/reset.
module tb_pipelined_dot_product;

   localparam int W = 32;
   localparam int N = 2;
   localparam int D = 1 + $clog2(N);

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_acc = 1'b0;
   logic           out_ready = 1'b1;
   logic [N*W-1:0] a = '0;
   logic [N*W-1:0] b = '0;
   logic           in_ready;
   logic           out_valid;
   logic [W-1:0]   c;

   logic           v4 = 1'b0;
   logic [4*W-1:0] a4 = '0;
   logic [4*W-1:0] b4 = '0;
   logic           rdy4;
   logic           ov4;
   logic [W-1:0]   c4;

   int total = 0;
   int bad = 0;

   pipelined_dot_product #(.N(N), .W(W)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_acc(in_acc), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .c(c)
   );

   pipelined_dot_product #(.N(4), .W(W)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4),
      .in_acc(1'b0), .a(a4), .b(b4), .out_valid(ov4),
      .out_ready(1'b1), .c(c4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- operation-level model ----------------
   typedef struct {
      logic [W-1:0] sum;
      bit           tag;
      int           age;
   } op_t;

   op_t          pipe_q[$];
   logic [W-1:0] lit_q[$];
   logic [W-1:0] m_c = '0;
   bit           m_ov = 1'b0;

   function automatic logic [W-1:0] dot(input logic [N*W-1:0] x, input logic [N*W-1:0] y);
      logic [W-1:0] s;
      s = '0;
      for (int i = 0; i < N; i++) s += x[i*W +: W] * y[i*W +: W];
      return s;
   endfunction

   // Each accepted op ages by one on every advancing edge and lands in c at age D.
   always @(posedge clk) begin
      bit  adv;
      bit  landed;
      op_t keep[$];
      op_t o;
      if (reset) begin
         pipe_q.delete();
         m_c  = '0;
         m_ov = 1'b0;
      end else begin
         adv = !m_ov || out_ready;
         if (adv) begin
            landed = 1'b0;
            keep.delete();
            foreach (pipe_q[j]) begin
               o = pipe_q[j];
               o.age++;
               if (o.age == D) begin
                  landed = 1'b1;
                  m_c = o.tag ? (m_c + o.sum) : o.sum;
               end else begin
                  keep.push_back(o);
               end
            end
            pipe_q = keep;
            m_ov = landed;
            if (in_valid) begin
               o.sum = dot(a, b);
               o.tag = in_acc;
               o.age = 1;
               pipe_q.push_back(o);
            end
         end
      end
   end

   always @(negedge clk) begin
      #2;
      check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      check("c", c, m_c);
      check("in_ready", {31'b0, in_ready}, {31'b0, (!m_ov || out_ready)});
      if (out_valid && out_ready && lit_q.size() > 0) check("lit_c", c, lit_q.pop_front());
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [W-1:0] a0, input logic [W-1:0] a1,
                       input logic [W-1:0] b0, input logic [W-1:0] b1, input bit acc);
      int n;
      n = 0;
      a = {a1, a0};
      b = {b1, b0};
      in_acc = acc;
      in_valid = 1'b1;
      #1;
      while (!in_ready) begin
         @(negedge clk);
         #1;
         n++;
         if (n > 50) begin
            check("send_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #2;
      check("rst_ov", {31'b0, out_valid}, 32'd0);
      check("rst_c", c, 32'd0);
      check("rst_rdy", {31'b0, in_ready}, 32'd1);
      @(negedge clk);

      // single op, exact latency of 2
      send(3, 4, 5, 6, 0);
      #2 check("single_lat1", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      #2 check("single_ov", {31'b0, out_valid}, 32'd1);
      check("single_c", c, 32'd39);
      @(negedge clk);
      #2 check("single_drop", {31'b0, out_valid}, 32'd0);
      check("single_hold", c, 32'd39);
      @(negedge clk);

      // streaming
      for (int k = 1; k <= 8; k++) begin
         lit_q.push_back(k*k + 1);
         send(k, 1, k, 1, 0);
      end
      repeat (4) @(negedge clk);

      // accumulate
      lit_q.push_back(2); lit_q.push_back(10); lit_q.push_back(14);
      send(1, 1, 1, 1, 0);
      send(2, 3, 1, 2, 1);
      send(1, 0, 4, 0, 1);
      repeat (4) @(negedge clk);

      // wrap-around
      lit_q.push_back(32'hFFFF_FFFF); lit_q.push_back(5);
      lit_q.push_back(32'hFFFF_FFFF); lit_q.push_back(1);
      send(32'hFFFF_FFFF, 1, 2, 1, 0);
      send(32'h8000_0000, 5, 2, 1, 0);
      send(32'hFFFF_FFFF, 0, 1, 0, 0);
      send(2, 0, 1, 0, 1);
      repeat (4) @(negedge clk);

      // backpressure
      for (int k = 1; k <= 4; k++) lit_q.push_back(10 + k);
      fork
         begin
            for (int k = 1; k <= 4; k++) send(10 + k, 0, 1, 0, 0);
         end
         begin
            n = 0;
            while (!out_valid && n < 20) begin
               @(negedge clk);
               n++;
            end
            check("stall_seen", {31'b0, out_valid}, 32'd1);
            out_ready = 1'b0;
            #3;
            check("stall_rdy", {31'b0, in_ready}, 32'd0);
            check("stall_c", c, 32'd11);
            repeat (5) @(negedge clk);
            check("stall_frozen", c, 32'd11);
            out_ready = 1'b1;
         end
      join
      repeat (8) @(negedge clk);

      // N=4 latency
      a4 = {32'd4, 32'd3, 32'd2, 32'd1};
      b4 = {32'd8, 32'd7, 32'd6, 32'd5};
      v4 = 1'b1;
      @(negedge clk);
      v4 = 1'b0;
      #2 check("n4_lat1", {31'b0, ov4}, 32'd0);
      @(negedge clk);
      #2 check("n4_lat2", {31'b0, ov4}, 32'd0);
      @(negedge clk);
      #2 check("n4_ov", {31'b0, ov4}, 32'd1);
      check("n4_c", c4, 32'd70);
      @(negedge clk);
      #2 check("n4_drop", {31'b0, ov4}, 32'd0);
      @(negedge clk);

      // reset with operations in flight on both instances
      a4 = {4{32'd1}}; b4 = {4{32'd1}}; v4 = 1'b1;
      @(negedge clk);
      a4 = {4{32'd2}}; b4 = {4{32'd2}};
      a = {32'd0, 32'd5}; b = {32'd0, 32'd5}; in_acc = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      v4 = 1'b0; in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #2 check("rst_mid_ov", {31'b0, out_valid}, 32'd0);
      check("rst_mid_c", c, 32'd0);
      check("rst_mid_ov4", {31'b0, ov4}, 32'd0);
      check("rst_mid_c4", c4, 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #2 check("no_stale4", {31'b0, ov4}, 32'd0);
      end
      @(negedge clk);
      lit_q.push_back(6);
      send(2, 0, 3, 0, 1);
      repeat (4) @(negedge clk);

      check("lit_left", lit_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
